alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Issue-side driver for the execute-stage `FunctionUnit`. It accepts a raw RV32I instruction plus operand values over a valid/ready handshake. It decodes the function select (FS) and the A/B operands that `FunctionUnit` consumes, then captures the returned result and ZCNV flags in a one-entry output register. For conditional branches it resolves taken/not-taken from the flags. It sits between the register-read stage and writeback/branch resolution.

## Interface
- No parameters; all data paths are 32 bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction and operands valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_instr`  in  32  raw instruction word.
- `in_rs1`, `in_rs2`  in  32  register operand values.
- `in_pc`  in  32  instruction address.
- `fu_a`, `fu_b`  out  32  operands to `FunctionUnit` (combinational from inputs).
- `fu_fs`  out  4  FS code to `FunctionUnit` (combinational).
- `fu_s`  in  32  `FunctionUnit` result.
- `fu_flags`  in  4  ZCNV flags: bit3 Z, bit2 C, bit1 N, bit0 V.
- `out_valid`  out  1  registered result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  32  captured result.
- `out_branch`  out  1  captured instruction was a conditional branch.
- `out_taken`  out  1  branch condition true.
- `out_illegal`  out  1  instruction not decodable by this stage.
- `out_count`  out  32  number of results consumed (output handshakes) since reset.

## Operation
- FS codes: ADD 0000, SUB 0001, SLL 0010, SLT 0100, SLTU 0110, XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110.
- Opcode decode, with funct3 = instr[14:12] and f7 = instr[31:25]:
  - OP (0110011): A=rs1, B=rs2.
    - funct3 000: ADD when f7=0000000, SUB when f7=0100000.
    - funct3 101: SRL when f7=0000000, SRA when f7=0100000.
    - Other funct3 (001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND) require f7=0000000.
    - Any other f7 is illegal.
  - OP-IMM (0010011): A=rs1, B=sign-extended instr[31:20], funct3 mapped as for OP.
    - funct3 000 is always ADD (no SUBI).
    - funct3 001 requires f7=0000000, else illegal.
    - funct3 101: SRL when f7=0000000, SRA when f7=0100000, else illegal.
  - LUI (0110111): A=0, B={instr[31:12],12'b0}, FS=ADD.
  - AUIPC (0010111): A=pc, B={instr[31:12],12'b0}, FS=ADD.
  - BRANCH (1100011): A=rs1, B=rs2, FS=SUB, branch=1.
    - BEQ 000: taken=Z.
    - BNE 001: taken=!Z.
    - BLT 100: taken=N^V.
    - BGE 101: taken=!(N^V).
    - BLTU 110: taken=!C.
    - BGEU 111: taken=C.
    - C=1 means no borrow, i.e. A≥B unsigned.
    - funct3 010/011 are illegal.
  - Any other opcode is illegal.
- Illegal instruction: FS=ADD, A=B=0. Capture result=0, branch=0, taken=0, illegal=1.
- Non-branch instructions capture taken=0.
- Output register states:
  - EMPTY (out_valid=0) → FULL on accept.
  - FULL → EMPTY on out_ready & !in_valid.
  - FULL → FULL (reload) on out_ready & in_valid.
  - FULL holds all output fields unchanged while out_ready=0.
- `in_ready = !rst & (!out_valid | out_ready)`.
- An accept is `in_valid & in_ready`.
- `out_count` increments by 1 on each `out_valid & out_ready` and wraps 0xFFFFFFFF→0.

## Timing
- Reset values:
  - out_valid=0, out_result=0, out_branch=0, out_taken=0, out_illegal=0, out_count=0.
  - in_ready=0 during the reset cycle and 1 on the first cycle after reset.
- fu_a, fu_b and fu_fs are combinational from the current inputs. `fu_s`/`fu_flags` are sampled at the accept edge; the path is in → decode → FunctionUnit → capture, all in one cycle.
- Latency: an accept at edge N makes the output visible with out_valid=1 after edge N.
- Throughput: 1 instruction/cycle when out_ready is held at 1. No bubble on a simultaneous drain and reload.
- Backpressure: out_ready=0 while FULL drops in_ready to 0 in the same cycle. No data is lost or overwritten.
- If rst is asserted mid-operation, it wins over any handshake in that cycle:
  - a pending result is discarded;
  - out_count clears;
  - the handshake is not counted.
- Outputs never change while `out_valid & !out_ready`.

## Test plan
- ADD x: instr 0x002081B3 (add), rs1=5, rs2=7 → fu_fs=0000; next cycle out_result=12, illegal=0, branch=0.
- SRAI: instr 0x4040D093, rs1=0x80000000 → fu_fs=1011, fu_b[4:0]=4; out_result=0xF8000000.
- Branches, rs1=0xFFFFFFFF, rs2=1:
  - BLT (funct3 100) → taken=1.
  - BLTU (funct3 110) → taken=0.
  - BEQ with rs1=rs2=3 → taken=1.
  - The same BEQ form with rs1=3, rs2=4 (BNE, funct3 001) → taken=1.
- Illegal: opcode 0x7F, and OP with f7=0000001 → out_illegal=1, out_result=0, fu_fs=0000.
- Backpressure:
  - Stream 4 ADDs with out_ready low for 3 cycles after the first result → in_ready=0 and out_result held constant during the stall.
  - Then all 4 results appear in order; out_count=4.
- Reset during FULL with in_valid=1 → the next cycle shows out_valid=0, out_count=0, in_ready=1.
- LUI 0x12345 then AUIPC 0x1 at pc=0x100 → results 0x12345000 and 0x00001100, back-to-back.

Source files
------------

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I ALU issue stage: decode to FunctionUnit, capture result, resolve branches
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_pc,
  output logic [31:0] fu_a,
  output logic [31:0] fu_b,
  output logic [3:0]  fu_fs,
  input  logic [31:0] fu_s,
  input  logic [3:0]  fu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_branch,
  output logic        out_taken,
  output logic        out_illegal,
  output logic [31:0] out_count
);

  localparam logic [3:0] FS_ADD  = 4'b0000;
  localparam logic [3:0] FS_SUB  = 4'b0001;
  localparam logic [3:0] FS_SLL  = 4'b0010;
  localparam logic [3:0] FS_SLT  = 4'b0100;
  localparam logic [3:0] FS_SLTU = 4'b0110;
  localparam logic [3:0] FS_XOR  = 4'b1000;
  localparam logic [3:0] FS_SRL  = 4'b1010;
  localparam logic [3:0] FS_SRA  = 4'b1011;
  localparam logic [3:0] FS_OR   = 4'b1100;
  localparam logic [3:0] FS_AND  = 4'b1110;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t      state_q, state_d;
  logic        load;
  logic [31:0] result_q, result_d;
  logic        branch_q, branch_d;
  logic        taken_q, taken_d;
  logic        illegal_q, illegal_d;
  logic [31:0] count_q, count_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  f7;
  logic        legal;
  logic        is_branch;
  logic        cond;
  logic        unused_rd;

  assign opcode    = in_instr[6:0];
  assign funct3    = in_instr[14:12];
  assign f7        = in_instr[31:25];
  assign unused_rd = ^in_instr[11:7];

  // funct3 to FS for the register/immediate ALU ops where f7 does not select a variant
  function automatic logic [3:0] base_fs(input logic [2:0] f3);
    case (f3)
      3'b000:  base_fs = FS_ADD;
      3'b001:  base_fs = FS_SLL;
      3'b010:  base_fs = FS_SLT;
      3'b011:  base_fs = FS_SLTU;
      3'b100:  base_fs = FS_XOR;
      3'b101:  base_fs = FS_SRL;
      3'b110:  base_fs = FS_OR;
      default: base_fs = FS_AND;
    endcase
  endfunction

  // Decode instruction into FunctionUnit operands and FS; illegal forms present ADD 0+0
  always_comb begin
    fu_fs     = FS_ADD;
    fu_a      = 32'd0;
    fu_b      = 32'd0;
    legal     = 1'b0;
    is_branch = 1'b0;
    case (opcode)
      OPC_OP: begin
        fu_a = in_rs1;
        fu_b = in_rs2;
        if (funct3 == 3'b000 || funct3 == 3'b101) begin
          if (f7 == F7_ZERO) begin
            legal = 1'b1;
            fu_fs = base_fs(funct3);
          end else if (f7 == F7_ALT) begin
            legal = 1'b1;
            fu_fs = (funct3 == 3'b000) ? FS_SUB : FS_SRA;
          end
        end else if (f7 == F7_ZERO) begin
          legal = 1'b1;
          fu_fs = base_fs(funct3);
        end
      end
      OPC_OP_IMM: begin
        fu_a = in_rs1;
        fu_b = {{20{in_instr[31]}}, in_instr[31:20]};
        if (funct3 == 3'b001) begin
          legal = (f7 == F7_ZERO);
          fu_fs = FS_SLL;
        end else if (funct3 == 3'b101) begin
          legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
          fu_fs = (f7 == F7_ALT) ? FS_SRA : FS_SRL;
        end else begin
          legal = 1'b1;
          fu_fs = base_fs(funct3);
        end
      end
      OPC_LUI: begin
        legal = 1'b1;
        fu_b  = {in_instr[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        fu_a  = in_pc;
        fu_b  = {in_instr[31:12], 12'd0};
      end
      OPC_BRANCH: begin
        legal     = (funct3 != 3'b010) && (funct3 != 3'b011);
        is_branch = 1'b1;
        fu_fs     = FS_SUB;
        fu_a      = in_rs1;
        fu_b      = in_rs2;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      fu_fs     = FS_ADD;
      fu_a      = 32'd0;
      fu_b      = 32'd0;
      is_branch = 1'b0;
    end
  end

  // Branch condition from the SUB flags; C=1 means rs1 >= rs2 unsigned
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = fu_flags[3];
      3'b001:  cond = !fu_flags[3];
      3'b100:  cond = fu_flags[1] ^ fu_flags[0];
      3'b101:  cond = !(fu_flags[1] ^ fu_flags[0]);
      3'b110:  cond = !fu_flags[2];
      3'b111:  cond = fu_flags[2];
      default: cond = 1'b0;
    endcase
  end

  // Output register occupancy: load on accept, drain when consumed with nothing behind it
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (out_ready) begin
          load    = in_valid;
          state_d = in_valid ? S_FULL : S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  assign in_ready  = !rst && ((state_q == S_EMPTY) || out_ready);
  assign out_valid = (state_q == S_FULL);

  assign result_d  = legal ? fu_s : 32'd0;
  assign branch_d  = is_branch;
  assign taken_d   = is_branch && cond;
  assign illegal_d = !legal;
  assign count_d   = count_q + {31'd0, out_valid && out_ready};

  // State, captured result fields and consumed-result counter; reset overrides any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      result_q  <= 32'd0;
      branch_q  <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (load) begin
        result_q  <= result_d;
        branch_q  <= branch_d;
        taken_q   <= taken_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign out_result  = result_q;
  assign out_branch  = branch_q;
  assign out_taken   = taken_q;
  assign out_illegal = illegal_q;
  assign out_count   = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage with a behavioural FunctionUnit
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr, in_rs1, in_rs2, in_pc;
  logic [31:0] fu_a, fu_b;
  logic [3:0]  fu_fs;
  logic [31:0] fu_s;
  logic [3:0]  fu_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_branch, out_taken, out_illegal;
  logic [31:0] out_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] result;
    logic        branch;
    logic        taken;
    logic        illegal;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc),
    .fu_a(fu_a), .fu_b(fu_b), .fu_fs(fu_fs), .fu_s(fu_s), .fu_flags(fu_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_branch(out_branch), .out_taken(out_taken), .out_illegal(out_illegal),
    .out_count(out_count)
  );

  // Behavioural FunctionUnit
  logic [32:0] fu_wide;
  logic        fu_c, fu_v;
  always_comb begin
    fu_wide = 33'd0;
    fu_s    = 32'd0;
    fu_c    = 1'b0;
    fu_v    = 1'b0;
    case (fu_fs)
      4'b0000: begin
        fu_wide = {1'b0, fu_a} + {1'b0, fu_b};
        fu_s = fu_wide[31:0]; fu_c = fu_wide[32];
        fu_v = (fu_a[31] == fu_b[31]) && (fu_s[31] != fu_a[31]);
      end
      4'b0001: begin
        fu_wide = {1'b0, fu_a} + {1'b0, ~fu_b} + 33'd1;
        fu_s = fu_wide[31:0]; fu_c = fu_wide[32];
        fu_v = (fu_a[31] != fu_b[31]) && (fu_s[31] != fu_a[31]);
      end
      4'b0010: fu_s = fu_a << fu_b[4:0];
      4'b0100: fu_s = {31'd0, $signed(fu_a) < $signed(fu_b)};
      4'b0110: fu_s = {31'd0, fu_a < fu_b};
      4'b1000: fu_s = fu_a ^ fu_b;
      4'b1010: fu_s = fu_a >> fu_b[4:0];
      4'b1011: fu_s = $unsigned($signed(fu_a) >>> fu_b[4:0]);
      4'b1100: fu_s = fu_a | fu_b;
      4'b1110: fu_s = fu_a & fu_b;
      default: fu_s = 32'd0;
    endcase
    fu_flags = {fu_s == 32'd0, fu_c, fu_s[31], fu_v};
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: pop and compare whenever a result is consumed
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got result=0x%08h with empty scoreboard", out_result);
        end else begin
          e = sb.pop_front();
          if (out_result !== e.result || out_branch !== e.branch ||
              out_taken !== e.taken || out_illegal !== e.illegal) begin
            errors++;
            $display("FAIL result: got r=0x%08h b=%0b t=%0b i=%0b expected r=0x%08h b=%0b t=%0b i=%0b",
                     out_result, out_branch, out_taken, out_illegal,
                     e.result, e.branch, e.taken, e.illegal);
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] pc, input logic [3:0] fs, input logic [31:0] res,
                      input logic br, input logic tk, input logic il);
    int n;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_instr = instr; in_rs1 = rs1; in_rs2 = rs2; in_pc = pc;
    #1;
    check32("fu_fs", {28'd0, fu_fs}, {28'd0, fs});
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=0 expected 1 within 50 cycles");
      in_valid = 1'b0;
    end else begin
      e.result = res; e.branch = br; e.taken = tk; e.illegal = il;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check32("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'd0; in_rs1 = 32'd0; in_rs2 = 32'd0; in_pc = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check32("rst_out_valid", {31'd0, out_valid}, 0);
    check32("rst_out_result", out_result, 0);
    check32("rst_flags", {29'd0, out_branch, out_taken, out_illegal}, 0);
    check32("rst_out_count", out_count, 0);
    check32("rst_in_ready", {31'd0, in_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check32("post_rst_in_ready", {31'd0, in_ready}, 1);

    send(32'h002081B3, 32'd5, 32'd7, 32'd0, 4'b0000, 32'd12, 1'b0, 1'b0, 1'b0);
    send(32'h4040D093, 32'h80000000, 32'd0, 32'd0, 4'b1011, 32'hF8000000, 1'b0, 1'b0, 1'b0);
    check32("srai_fu_b", {27'd0, fu_b[4:0]}, 32'd4);
    send(32'h0020C063, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0001, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0);
    send(32'h0020E063, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0001, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
    send(32'h0020D063, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0001, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
    send(32'h0020F063, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0001, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0);
    send(32'h00208063, 32'd3, 32'd3, 32'd0, 4'b0001, 32'd0, 1'b1, 1'b1, 1'b0);
    send(32'h00209063, 32'd3, 32'd4, 32'd0, 4'b0001, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
    send(32'h0000007F, 32'd9, 32'd9, 32'd0, 4'b0000, 32'd0, 1'b0, 1'b0, 1'b1);
    send(32'h022081B3, 32'd9, 32'd9, 32'd0, 4'b0000, 32'd0, 1'b0, 1'b0, 1'b1);
    send(32'h0000A063, 32'd9, 32'd9, 32'd0, 4'b0000, 32'd0, 1'b0, 1'b0, 1'b1);
    send(32'h123450B7, 32'd9, 32'd9, 32'h100, 4'b0000, 32'h12345000, 1'b0, 1'b0, 1'b0);
    send(32'h00001097, 32'd9, 32'd9, 32'h100, 4'b0000, 32'h00001100, 1'b0, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    #3;
    check32("count_after_directed", out_count, 32'd13);

    // Reset while FULL and a new instruction is offered
    out_ready = 1'b0;
    send(32'h002081B3, 32'd1, 32'd1, 32'd0, 4'b0000, 32'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3;
    #1;
    check32("rst_mid_in_ready", {31'd0, in_ready}, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    sb.delete();
    #1;
    check32("rst_mid_out_valid", {31'd0, out_valid}, 0);
    check32("rst_mid_out_count", out_count, 0);
    check32("rst_mid_in_ready_after", {31'd0, in_ready}, 1);
    out_ready = 1'b1;

    // Backpressure: stall 3 cycles on the first of four results
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(32'h002081B3, i, 32'd100, 32'd0, 4'b0000, 32'd100 + i, 1'b0, 1'b0, 1'b0);
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 50);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #2;
          check32("stall_in_ready", {31'd0, in_ready}, 0);
          check32("stall_result_held", out_result, 32'd100);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    @(negedge clk);
    #3;
    check32("bp_out_count", out_count, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
